// File: rtl/stage1_butterfly_all.sv
// First radix-2 DIT stage of the 16-point FFT: eight W^0 butterflies on adjacent
// bit-reversed pairs, registered once, wrapping modulo 2^WIDTH on overflow.
module stage1_butterfly_all #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] xr_in0,
    input  logic signed [WIDTH-1:0] xr_in1,
    input  logic signed [WIDTH-1:0] xr_in2,
    input  logic signed [WIDTH-1:0] xr_in3,
    input  logic signed [WIDTH-1:0] xr_in4,
    input  logic signed [WIDTH-1:0] xr_in5,
    input  logic signed [WIDTH-1:0] xr_in6,
    input  logic signed [WIDTH-1:0] xr_in7,
    input  logic signed [WIDTH-1:0] xr_in8,
    input  logic signed [WIDTH-1:0] xr_in9,
    input  logic signed [WIDTH-1:0] xr_in10,
    input  logic signed [WIDTH-1:0] xr_in11,
    input  logic signed [WIDTH-1:0] xr_in12,
    input  logic signed [WIDTH-1:0] xr_in13,
    input  logic signed [WIDTH-1:0] xr_in14,
    input  logic signed [WIDTH-1:0] xr_in15,
    input  logic signed [WIDTH-1:0] xi_in0,
    input  logic signed [WIDTH-1:0] xi_in1,
    input  logic signed [WIDTH-1:0] xi_in2,
    input  logic signed [WIDTH-1:0] xi_in3,
    input  logic signed [WIDTH-1:0] xi_in4,
    input  logic signed [WIDTH-1:0] xi_in5,
    input  logic signed [WIDTH-1:0] xi_in6,
    input  logic signed [WIDTH-1:0] xi_in7,
    input  logic signed [WIDTH-1:0] xi_in8,
    input  logic signed [WIDTH-1:0] xi_in9,
    input  logic signed [WIDTH-1:0] xi_in10,
    input  logic signed [WIDTH-1:0] xi_in11,
    input  logic signed [WIDTH-1:0] xi_in12,
    input  logic signed [WIDTH-1:0] xi_in13,
    input  logic signed [WIDTH-1:0] xi_in14,
    input  logic signed [WIDTH-1:0] xi_in15,
    output logic signed [WIDTH-1:0] yr_out0,
    output logic signed [WIDTH-1:0] yr_out1,
    output logic signed [WIDTH-1:0] yr_out2,
    output logic signed [WIDTH-1:0] yr_out3,
    output logic signed [WIDTH-1:0] yr_out4,
    output logic signed [WIDTH-1:0] yr_out5,
    output logic signed [WIDTH-1:0] yr_out6,
    output logic signed [WIDTH-1:0] yr_out7,
    output logic signed [WIDTH-1:0] yr_out8,
    output logic signed [WIDTH-1:0] yr_out9,
    output logic signed [WIDTH-1:0] yr_out10,
    output logic signed [WIDTH-1:0] yr_out11,
    output logic signed [WIDTH-1:0] yr_out12,
    output logic signed [WIDTH-1:0] yr_out13,
    output logic signed [WIDTH-1:0] yr_out14,
    output logic signed [WIDTH-1:0] yr_out15,
    output logic signed [WIDTH-1:0] yi_out0,
    output logic signed [WIDTH-1:0] yi_out1,
    output logic signed [WIDTH-1:0] yi_out2,
    output logic signed [WIDTH-1:0] yi_out3,
    output logic signed [WIDTH-1:0] yi_out4,
    output logic signed [WIDTH-1:0] yi_out5,
    output logic signed [WIDTH-1:0] yi_out6,
    output logic signed [WIDTH-1:0] yi_out7,
    output logic signed [WIDTH-1:0] yi_out8,
    output logic signed [WIDTH-1:0] yi_out9,
    output logic signed [WIDTH-1:0] yi_out10,
    output logic signed [WIDTH-1:0] yi_out11,
    output logic signed [WIDTH-1:0] yi_out12,
    output logic signed [WIDTH-1:0] yi_out13,
    output logic signed [WIDTH-1:0] yi_out14,
    output logic signed [WIDTH-1:0] yi_out15
);

    localparam int unsigned N = 16;

    logic signed [WIDTH-1:0] xr [N];
    logic signed [WIDTH-1:0] xi [N];
    logic        [WIDTH:0]   sr [N];
    logic        [WIDTH:0]   si [N];
    logic signed [WIDTH-1:0] yr_q [N];
    logic signed [WIDTH-1:0] yi_q [N];

    // Flattened port lists gathered into arrays so the butterflies can be looped
    assign xr[0]  = xr_in0;   assign xi[0]  = xi_in0;
    assign xr[1]  = xr_in1;   assign xi[1]  = xi_in1;
    assign xr[2]  = xr_in2;   assign xi[2]  = xi_in2;
    assign xr[3]  = xr_in3;   assign xi[3]  = xi_in3;
    assign xr[4]  = xr_in4;   assign xi[4]  = xi_in4;
    assign xr[5]  = xr_in5;   assign xi[5]  = xi_in5;
    assign xr[6]  = xr_in6;   assign xi[6]  = xi_in6;
    assign xr[7]  = xr_in7;   assign xi[7]  = xi_in7;
    assign xr[8]  = xr_in8;   assign xi[8]  = xi_in8;
    assign xr[9]  = xr_in9;   assign xi[9]  = xi_in9;
    assign xr[10] = xr_in10;  assign xi[10] = xi_in10;
    assign xr[11] = xr_in11;  assign xi[11] = xi_in11;
    assign xr[12] = xr_in12;  assign xi[12] = xi_in12;
    assign xr[13] = xr_in13;  assign xi[13] = xi_in13;
    assign xr[14] = xr_in14;  assign xi[14] = xi_in14;
    assign xr[15] = xr_in15;  assign xi[15] = xi_in15;

    // Sums formed at WIDTH+1 bits; only the low WIDTH bits are kept (modular wrap)
    always_comb begin
        for (int unsigned k = 0; k < N / 2; k++) begin
            sr[2*k]   = {xr[2*k][WIDTH-1], xr[2*k]} + {xr[2*k+1][WIDTH-1], xr[2*k+1]};
            sr[2*k+1] = {xr[2*k][WIDTH-1], xr[2*k]} - {xr[2*k+1][WIDTH-1], xr[2*k+1]};
            si[2*k]   = {xi[2*k][WIDTH-1], xi[2*k]} + {xi[2*k+1][WIDTH-1], xi[2*k+1]};
            si[2*k+1] = {xi[2*k][WIDTH-1], xi[2*k]} - {xi[2*k+1][WIDTH-1], xi[2*k+1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                yr_q[i] <= '0;
                yi_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                yr_q[i] <= sr[i][WIDTH-1:0];
                yi_q[i] <= si[i][WIDTH-1:0];
            end
        end
    end

    assign yr_out0  = yr_q[0];   assign yi_out0  = yi_q[0];
    assign yr_out1  = yr_q[1];   assign yi_out1  = yi_q[1];
    assign yr_out2  = yr_q[2];   assign yi_out2  = yi_q[2];
    assign yr_out3  = yr_q[3];   assign yi_out3  = yi_q[3];
    assign yr_out4  = yr_q[4];   assign yi_out4  = yi_q[4];
    assign yr_out5  = yr_q[5];   assign yi_out5  = yi_q[5];
    assign yr_out6  = yr_q[6];   assign yi_out6  = yi_q[6];
    assign yr_out7  = yr_q[7];   assign yi_out7  = yi_q[7];
    assign yr_out8  = yr_q[8];   assign yi_out8  = yi_q[8];
    assign yr_out9  = yr_q[9];   assign yi_out9  = yi_q[9];
    assign yr_out10 = yr_q[10];  assign yi_out10 = yi_q[10];
    assign yr_out11 = yr_q[11];  assign yi_out11 = yi_q[11];
    assign yr_out12 = yr_q[12];  assign yi_out12 = yi_q[12];
    assign yr_out13 = yr_q[13];  assign yi_out13 = yi_q[13];
    assign yr_out14 = yr_q[14];  assign yi_out14 = yi_q[14];
    assign yr_out15 = yr_q[15];  assign yi_out15 = yi_q[15];

endmodule

// File: tb/tb_stage1_butterfly_all.sv
// Scoreboard bench for stage1_butterfly_all: expected frames queued at drive time,
// popped and compared one edge later; directed spec vectors plus random frames.
module tb_stage1_butterfly_all;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [W-1:0] xr [16];
    logic signed [W-1:0] xi [16];
    logic signed [W-1:0] yr [16];
    logic signed [W-1:0] yi [16];

    logic [16*W-1:0] q_r [$];
    logic [16*W-1:0] q_i [$];
    logic [16*W-1:0] last_r, last_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage1_butterfly_all #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .xr_in0(xr[0]),   .xr_in1(xr[1]),   .xr_in2(xr[2]),   .xr_in3(xr[3]),
        .xr_in4(xr[4]),   .xr_in5(xr[5]),   .xr_in6(xr[6]),   .xr_in7(xr[7]),
        .xr_in8(xr[8]),   .xr_in9(xr[9]),   .xr_in10(xr[10]), .xr_in11(xr[11]),
        .xr_in12(xr[12]), .xr_in13(xr[13]), .xr_in14(xr[14]), .xr_in15(xr[15]),
        .xi_in0(xi[0]),   .xi_in1(xi[1]),   .xi_in2(xi[2]),   .xi_in3(xi[3]),
        .xi_in4(xi[4]),   .xi_in5(xi[5]),   .xi_in6(xi[6]),   .xi_in7(xi[7]),
        .xi_in8(xi[8]),   .xi_in9(xi[9]),   .xi_in10(xi[10]), .xi_in11(xi[11]),
        .xi_in12(xi[12]), .xi_in13(xi[13]), .xi_in14(xi[14]), .xi_in15(xi[15]),
        .yr_out0(yr[0]),   .yr_out1(yr[1]),   .yr_out2(yr[2]),   .yr_out3(yr[3]),
        .yr_out4(yr[4]),   .yr_out5(yr[5]),   .yr_out6(yr[6]),   .yr_out7(yr[7]),
        .yr_out8(yr[8]),   .yr_out9(yr[9]),   .yr_out10(yr[10]), .yr_out11(yr[11]),
        .yr_out12(yr[12]), .yr_out13(yr[13]), .yr_out14(yr[14]), .yr_out15(yr[15]),
        .yi_out0(yi[0]),   .yi_out1(yi[1]),   .yi_out2(yi[2]),   .yi_out3(yi[3]),
        .yi_out4(yi[4]),   .yi_out5(yi[5]),   .yi_out6(yi[6]),   .yi_out7(yi[7]),
        .yi_out8(yi[8]),   .yi_out9(yi[9]),   .yi_out10(yi[10]), .yi_out11(yi[11]),
        .yi_out12(yi[12]), .yi_out13(yi[13]), .yi_out14(yi[14]), .yi_out15(yi[15])
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference butterfly: full-precision integer result wrapped to W bits
    function automatic logic [W-1:0] bfly(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b,
                                          input bit sub);
        int s;
        s = sub ? (int'(a) - int'(b)) : (int'(a) + int'(b));
        return s[W-1:0];
    endfunction

    task automatic drive(input logic signed [W-1:0] fr [16], input logic signed [W-1:0] fi [16]);
        logic [16*W-1:0] er, ei;
        for (int i = 0; i < 16; i++) begin
            xr[i] = fr[i];
            xi[i] = fi[i];
        end
        for (int k = 0; k < 8; k++) begin
            er[(2*k)*W +: W]   = bfly(fr[2*k], fr[2*k+1], 1'b0);
            er[(2*k+1)*W +: W] = bfly(fr[2*k], fr[2*k+1], 1'b1);
            ei[(2*k)*W +: W]   = bfly(fi[2*k], fi[2*k+1], 1'b0);
            ei[(2*k+1)*W +: W] = bfly(fi[2*k], fi[2*k+1], 1'b1);
        end
        q_r.push_back(er);
        q_i.push_back(ei);
    endtask

    task automatic compare_last(input string pfx);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_yr%0d", pfx, i), yr[i], last_r[i*W +: W]);
            check($sformatf("%s_yi%0d", pfx, i), yi[i], last_i[i*W +: W]);
        end
    endtask

    task automatic step(input string pfx);
        @(posedge clk);
        #1;
        check({pfx, "_sb_depth"}, W'(q_r.size()), W'(1));
        if (q_r.size() > 0) begin
            last_r = q_r.pop_front();
            last_i = q_i.pop_front();
            compare_last(pfx);
        end
    endtask

    task automatic check_zero(input string pfx);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_yr%0d", pfx, i), yr[i], '0);
            check($sformatf("%s_yi%0d", pfx, i), yi[i], '0);
        end
    endtask

    logic signed [W-1:0] fr [16];
    logic signed [W-1:0] fi [16];

    initial begin
        // Reset held with arbitrary inputs, before any clock edge
        for (int i = 0; i < 16; i++) begin
            fr[i] = W'(i * 37 + 5);
            fi[i] = W'(-i * 11 - 3);
        end
        for (int i = 0; i < 16; i++) begin xr[i] = fr[i]; xi[i] = fi[i]; end
        #2;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        drive(fr, fi);
        step("post_reset");

        // Ramp
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin fr[i] = W'(i); fi[i] = '0; end
        drive(fr, fi);
        step("ramp");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ramp_const_yr%0d", 2*k), yr[2*k], W'(4*k + 1));
            check($sformatf("ramp_const_yr%0d", 2*k+1), yr[2*k+1], 16'hFFFF);
        end

        // Imag-only
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin fr[i] = '0; fi[i] = W'(2 * i); end
        drive(fr, fi);
        step("imag");
        for (int k = 0; k < 8; k++) begin
            check($sformatf("imag_const_yi%0d", 2*k), yi[2*k], W'(8*k + 2));
            check($sformatf("imag_const_yi%0d", 2*k+1), yi[2*k+1], 16'hFFFE);
            check($sformatf("imag_const_yr%0d", 2*k), yr[2*k], '0);
        end

        // Mixed signs and overflow wrap in the same frame
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin fr[i] = W'(i * 3); fi[i] = W'(i - 8); end
        fr[0] = -16'sd100; fr[1] = 16'sd50; fi[0] = 16'sd7; fi[1] = -16'sd3;
        fr[2] = 16'sd32767; fr[3] = 16'sd1;
        fr[4] = -16'sd32768; fr[5] = 16'sd1;
        drive(fr, fi);
        step("mixed");
        check("mix_yr0", yr[0], -16'sd50);
        check("mix_yr1", yr[1], -16'sd150);
        check("mix_yi0", yi[0], 16'sd4);
        check("mix_yi1", yi[1], 16'sd10);
        check("ovf_yr2", yr[2], 16'h8000);
        check("ovf_yr3", yr[3], 16'sd32766);
        check("ovf_yr4", yr[4], -16'sd32767);
        check("ovf_yr5", yr[5], 16'sd32767);

        // Back-to-back random frames; mid-cycle input changes must not disturb outputs
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 16; i++) begin
                fr[i] = W'($urandom);
                fi[i] = W'($urandom);
            end
            drive(fr, fi);
            step($sformatf("rand%0d", n));
            for (int i = 0; i < 16; i++) begin
                xr[i] = W'($urandom);
                xi[i] = W'($urandom);
            end
            #2;
            if (n % 5 == 0) compare_last($sformatf("hold%0d", n));
        end

        // Async reset pulse between edges: outputs clear without a clock edge
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin fr[i] = W'(i + 100); fi[i] = W'(200 - i); end
        drive(fr, fi);
        #1;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        q_r.delete();
        q_i.delete();
        #1;
        rst = 1'b0;
        #1;
        check_zero("async_rst_hold");
        @(negedge clk);
        drive(fr, fi);
        step("after_async");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
